// File: rtl/dram_pkg.sv
// Shared types and machine-cycle phase numbers for the DRAM cycle arbiter.
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU     = 2'd1,
        DMA     = 2'd2,
        REFRESH = 2'd3
    } owner_e;

    localparam logic [3:0] PH_FIRST   = 4'd1;
    localparam logic [3:0] PH_RAS_ON  = 4'd2;
    localparam logic [3:0] PH_CAS_ON  = 4'd4;
    localparam logic [3:0] PH_WE_ON   = 4'd5;
    localparam logic [3:0] PH_WE_OFF  = 4'd7;
    localparam logic [3:0] PH_RAS_OFF = 4'd8;
    localparam logic [3:0] PH_LATCH   = 4'd8;
    localparam logic [3:0] PH_ACK     = 4'd9;
    localparam logic [3:0] PH_LAST    = 4'd10;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer, saturating refresh backlog, refresh row counter
// and sticky backlog-overflow flag.
module dram_refresh_timer #(
    parameter int unsigned ROW_W          = 8,
    parameter int unsigned REFRESH_CYCLES = 64
) (
    input  logic             xtal_in,
    input  logic             init_n,
    input  logic             tick,
    input  logic             grant,
    input  logic             row_inc,
    output logic [1:0]       pending,
    output logic [ROW_W-1:0] row,
    output logic             refresh_miss
);

    localparam int unsigned     TMR_W    = $clog2(REFRESH_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       pending_q, pending_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             miss_q, miss_d;
    logic             wrap;

    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        row_d     = row_q;
        miss_d    = miss_q;
        wrap      = 1'b0;
        if (tick) begin
            if (timer_q == TMR_LAST) begin
                timer_d = '0;
                wrap    = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
        // A wrap coinciding with a grant leaves the backlog unchanged.
        if (wrap && pending_q == 2'd3) begin
            miss_d = 1'b1;
        end
        if (wrap && !grant && pending_q != 2'd3) begin
            pending_d = pending_q + 2'd1;
        end else if (grant && !wrap) begin
            pending_d = pending_q - 2'd1;
        end
        if (row_inc) begin
            row_d = row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge xtal_in or negedge init_n) begin
        if (!init_n) begin
            timer_q   <= '0;
            pending_q <= 2'd0;
            row_q     <= '0;
            miss_q    <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
            miss_q    <= miss_d;
        end
    end

    assign pending      = pending_q;
    assign row          = row_q;
    assign refresh_miss = miss_q;

endmodule

// File: rtl/dram_cycle_arbiter.sv
// Grants each 10-phase machine cycle to CPU, DMA, refresh or idle and drives
// the multiplexed DRAM interface with registered strobes.
module dram_cycle_arbiter
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned ROW_W          = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned REFRESH_CYCLES = 64
) (
    input  logic              xtal_in,
    input  logic              init_n,
    input  logic [3:0]        t_num,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ROW_W-1:0]  ram_a,
    output logic              ram_ras_n,
    output logic              ram_cas_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_dout_oe,
    input  logic [DATA_W-1:0] ram_din,
    output logic              refresh_miss
);

    owner_e            owner_q, owner_d;
    logic              synced_q, synced_d;
    logic              cyc_we_q, cyc_we_d;
    logic [ADDR_W-1:0] cyc_addr_q, cyc_addr_d;
    logic [DATA_W-1:0] cyc_wdata_q, cyc_wdata_d;
    logic              ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic              oe_q, oe_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [ROW_W-1:0]  ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_dout_q, ram_dout_d, rdata_q, rdata_d;

    logic              tick, ref_grant, row_inc;
    logic [1:0]        pending;
    logic [ROW_W-1:0]  row;
    logic              t_valid, is_mem;
    logic [3:0]        ph_next;

    assign t_valid = (t_num >= PH_FIRST) && (t_num <= PH_LAST);
    assign ph_next = (t_num == PH_LAST) ? PH_FIRST : t_num + 4'd1;

    dram_refresh_timer #(
        .ROW_W          (ROW_W),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_timer (
        .xtal_in      (xtal_in),
        .init_n       (init_n),
        .tick         (tick),
        .grant        (ref_grant),
        .row_inc      (row_inc),
        .pending      (pending),
        .row          (row),
        .refresh_miss (refresh_miss)
    );

    always_comb begin
        owner_d     = owner_q;
        synced_d    = synced_q;
        cyc_we_d    = cyc_we_q;
        cyc_addr_d  = cyc_addr_q;
        cyc_wdata_d = cyc_wdata_q;
        ras_n_d     = 1'b1;
        cas_n_d     = 1'b1;
        we_n_d      = 1'b1;
        oe_d        = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        rdata_d     = rdata_q;
        tick        = 1'b0;
        ref_grant   = 1'b0;
        row_inc     = 1'b0;
        is_mem      = 1'b0;
        if (!t_valid) begin
            synced_d = 1'b0;
        end else begin
            if (t_num == PH_LAST) begin
                synced_d = 1'b1;
                tick     = 1'b1;
                if (pending >= 2'd2) begin
                    owner_d   = REFRESH;
                    ref_grant = 1'b1;
                end else if (dma_req) begin
                    owner_d     = DMA;
                    cyc_we_d    = dma_we;
                    cyc_addr_d  = dma_addr;
                    cyc_wdata_d = dma_wdata;
                end else if (cpu_req) begin
                    owner_d     = CPU;
                    cyc_we_d    = cpu_we;
                    cyc_addr_d  = cpu_addr;
                    cyc_wdata_d = cpu_wdata;
                end else if (pending != 2'd0) begin
                    owner_d   = REFRESH;
                    ref_grant = 1'b1;
                end else begin
                    owner_d = IDLE;
                end
            end else if (!synced_q) begin
                owner_d = IDLE;
            end
            if (synced_q && t_num == PH_LATCH) begin
                row_inc = (owner_q == REFRESH);
                if ((owner_q == CPU || owner_q == DMA) && !cyc_we_q) begin
                    rdata_d = ram_din;
                end
            end
            // Strobe levels for the phase being entered.
            is_mem = (owner_d == CPU) || (owner_d == DMA);
            if (owner_d != IDLE) begin
                if (ph_next < PH_CAS_ON) begin
                    ram_a_d = (owner_d == REFRESH) ? row : cyc_addr_d[ROW_W-1:0];
                end else if (is_mem) begin
                    ram_a_d = cyc_addr_d[ADDR_W-1:ROW_W];
                end
                ras_n_d = !(ph_next >= PH_RAS_ON && ph_next <= PH_RAS_OFF);
            end
            if (is_mem) begin
                cas_n_d = !(ph_next >= PH_CAS_ON && ph_next <= PH_RAS_OFF);
                if (cyc_we_d) begin
                    we_n_d = !(ph_next >= PH_WE_ON && ph_next <= PH_WE_OFF);
                    if (ph_next >= PH_CAS_ON && ph_next <= PH_RAS_OFF) begin
                        oe_d       = 1'b1;
                        ram_dout_d = cyc_wdata_d;
                    end
                end
                if (ph_next == PH_ACK) begin
                    cpu_ack_d = (owner_d == CPU);
                    dma_ack_d = (owner_d == DMA);
                end
            end
        end
    end

    always_ff @(posedge xtal_in or negedge init_n) begin
        if (!init_n) begin
            owner_q     <= IDLE;
            synced_q    <= 1'b0;
            cyc_we_q    <= 1'b0;
            cyc_addr_q  <= '0;
            cyc_wdata_q <= '0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            rdata_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            synced_q    <= synced_d;
            cyc_we_q    <= cyc_we_d;
            cyc_addr_q  <= cyc_addr_d;
            cyc_wdata_q <= cyc_wdata_d;
            ras_n_q     <= ras_n_d;
            cas_n_q     <= cas_n_d;
            we_n_q      <= we_n_d;
            oe_q        <= oe_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            rdata_q     <= rdata_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;
    assign rdata       = rdata_q;
    assign ram_a       = ram_a_q;
    assign ram_ras_n   = ras_n_q;
    assign ram_cas_n   = cas_n_q;
    assign ram_we_n    = we_n_q;
    assign ram_dout    = ram_dout_q;
    assign ram_dout_oe = oe_q;

endmodule

// File: tb/tb_dram_cycle_arbiter.sv
// Directed bench: one arbiter with the default refresh interval (a) and one
// with REFRESH_CYCLES=2 (b), sharing all inputs.
module tb_dram_cycle_arbiter;

    logic        clk = 1'b0;
    logic        init_n;
    logic [3:0]  t_num;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, ram_din;

    logic [7:0]  rdata_a, ram_a_a, dout_a, rdata_b, ram_a_b, dout_b;
    logic        ras_a, cas_a, we_a, oe_a, cack_a, dack_a, miss_a;
    logic        ras_b, cas_b, we_b, oe_b, cack_b, dack_b, miss_b;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic       c_ras[1:10], c_cas[1:10], c_we[1:10], c_oe[1:10];
    logic       c_cack[1:10], c_dack[1:10];
    logic [7:0] c_a[1:10], c_dout[1:10];

    always #5 clk = ~clk;

    dram_cycle_arbiter #(.ADDR_W(16), .ROW_W(8), .DATA_W(8), .REFRESH_CYCLES(64)) u_dut_a (
        .xtal_in(clk), .init_n(init_n), .t_num(t_num),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cack_a),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dack_a),
        .rdata(rdata_a), .ram_a(ram_a_a), .ram_ras_n(ras_a), .ram_cas_n(cas_a), .ram_we_n(we_a),
        .ram_dout(dout_a), .ram_dout_oe(oe_a), .ram_din(ram_din), .refresh_miss(miss_a)
    );

    dram_cycle_arbiter #(.ADDR_W(16), .ROW_W(8), .DATA_W(8), .REFRESH_CYCLES(2)) u_dut_b (
        .xtal_in(clk), .init_n(init_n), .t_num(t_num),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cack_b),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dack_b),
        .rdata(rdata_b), .ram_a(ram_a_b), .ram_ras_n(ras_b), .ram_cas_n(cas_b), .ram_we_n(we_b),
        .ram_dout(dout_b), .ram_dout_oe(oe_b), .ram_din(ram_din), .refresh_miss(miss_b)
    );

    task automatic step(input logic [3:0] t);
        t_num = t;
        @(posedge clk);
        #1;
    endtask

    task automatic grab(input int ph);
        if (sel == 0) begin
            c_ras[ph] = ras_a; c_cas[ph] = cas_a; c_we[ph] = we_a; c_oe[ph] = oe_a;
            c_cack[ph] = cack_a; c_dack[ph] = dack_a; c_a[ph] = ram_a_a; c_dout[ph] = dout_a;
        end else begin
            c_ras[ph] = ras_b; c_cas[ph] = cas_b; c_we[ph] = we_b; c_oe[ph] = oe_b;
            c_cack[ph] = cack_b; c_dack[ph] = dack_b; c_a[ph] = ram_a_b; c_dout[ph] = dout_b;
        end
    endtask

    // Arbitration edge then phases 1..10 of the granted machine cycle.
    task automatic cycle();
        step(4'd10);
        grab(1);
        for (int p = 1; p <= 9; p++) begin
            step(4'(p));
            grab(p + 1);
        end
    endtask

    task automatic do_reset();
        init_n = 1'b0;
        @(posedge clk);
        #1;
        init_n = 1'b1;
    endtask

    task automatic test_reset();
        init_n = 1'b0; t_num = 4'd1; ram_din = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ras_a, cas_a, we_a, oe_a, cack_a, dack_a, miss_a} !== 7'b1110000) begin
            bad++; $display("FAIL reset_ctl_a got %b want 1110000", {ras_a, cas_a, we_a, oe_a, cack_a, dack_a, miss_a});
        end
        total++;
        if ({ram_a_a, dout_a, rdata_a} !== 24'h0) begin
            bad++; $display("FAIL reset_data_a got %h want 000000", {ram_a_a, dout_a, rdata_a});
        end
        total++;
        if ({ras_b, cas_b, we_b, oe_b, cack_b, dack_b, miss_b, ram_a_b} !== 15'b1110000_00000000) begin
            bad++; $display("FAIL reset_b got %b", {ras_b, cas_b, we_b, oe_b, cack_b, dack_b, miss_b, ram_a_b});
        end
        init_n = 1'b1;
    endtask

    task automatic test_idle_refresh();
        int nerr;
        sel = 0;
        nerr = 0;
        for (int c = 1; c <= 64; c++) begin
            cycle();
            for (int ph = 1; ph <= 10; ph++)
                if ({c_ras[ph], c_cas[ph], c_we[ph], c_cack[ph], c_dack[ph]} !== 5'b11100) nerr++;
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL idle_before_refresh active_phases=%0d want 0", nerr);
        end
        cycle();
        for (int ph = 1; ph <= 10; ph++) begin
            logic er;
            er = !(ph >= 2 && ph <= 8);
            total++;
            if ({c_ras[ph], c_cas[ph], c_we[ph], c_oe[ph], c_cack[ph], c_dack[ph]} !== {er, 5'b11000}) begin
                bad++; $display("FAIL refresh_strobes ph%0d got %b want %b", ph,
                    {c_ras[ph], c_cas[ph], c_we[ph], c_oe[ph], c_cack[ph], c_dack[ph]}, {er, 5'b11000});
            end
            if (ph <= 3) begin
                total++;
                if (c_a[ph] !== 8'h00) begin
                    bad++; $display("FAIL refresh_row ph%0d got %h want 00", ph, c_a[ph]);
                end
            end
        end
    endtask

    task automatic test_cpu_read();
        sel = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h12A5; ram_din = 8'h3C;
        cycle();
        cpu_req = 1'b0; ram_din = 8'hEE;
        for (int ph = 1; ph <= 10; ph++) begin
            logic [7:0] ea;
            logic       er, ec, ek;
            ea = (ph <= 3) ? 8'hA5 : 8'h12;
            er = !(ph >= 2 && ph <= 8);
            ec = !(ph >= 4 && ph <= 8);
            ek = (ph == 9);
            total++;
            if ({c_ras[ph], c_cas[ph], c_we[ph], c_oe[ph], c_cack[ph], c_dack[ph]} !== {er, ec, 1'b1, 1'b0, ek, 1'b0}) begin
                bad++; $display("FAIL cpu_read_strobes ph%0d got %b want %b", ph,
                    {c_ras[ph], c_cas[ph], c_we[ph], c_oe[ph], c_cack[ph], c_dack[ph]}, {er, ec, 1'b1, 1'b0, ek, 1'b0});
            end
            total++;
            if (c_a[ph] !== ea) begin
                bad++; $display("FAIL cpu_read_addr ph%0d got %h want %h", ph, c_a[ph], ea);
            end
        end
        total++;
        if (rdata_a !== 8'h3C) begin
            bad++; $display("FAIL cpu_read_rdata got %h want 3c", rdata_a);
        end
    endtask

    task automatic test_priority();
        sel = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h55;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 8'h77;
        for (int c = 0; c < 2; c++) begin
            logic [7:0] lo, hi, wd;
            logic       is_dma;
            cycle();
            is_dma = (c == 0);
            if (is_dma) dma_req = 1'b0;
            else        cpu_req = 1'b0;
            lo = is_dma ? 8'h40 : 8'h34;
            hi = is_dma ? 8'h00 : 8'h12;
            wd = is_dma ? 8'h77 : 8'h55;
            for (int ph = 1; ph <= 10; ph++) begin
                logic ec, ew, eo, ek;
                ec = !(ph >= 4 && ph <= 8);
                ew = !(ph >= 5 && ph <= 7);
                eo = (ph >= 4 && ph <= 8);
                ek = (ph == 9);
                total++;
                if ({c_cas[ph], c_we[ph], c_oe[ph], c_dack[ph], c_cack[ph]} !== {ec, ew, eo, ek & is_dma, ek & !is_dma}) begin
                    bad++; $display("FAIL write%0d_strobes ph%0d got %b want %b", c, ph,
                        {c_cas[ph], c_we[ph], c_oe[ph], c_dack[ph], c_cack[ph]}, {ec, ew, eo, ek & is_dma, ek & !is_dma});
                end
                total++;
                if (c_a[ph] !== ((ph <= 3) ? lo : hi)) begin
                    bad++; $display("FAIL write%0d_addr ph%0d got %h want %h", c, ph, c_a[ph], (ph <= 3) ? lo : hi);
                end
                if (eo) begin
                    total++;
                    if (c_dout[ph] !== wd) begin
                        bad++; $display("FAIL write%0d_dout ph%0d got %h want %h", c, ph, c_dout[ph], wd);
                    end
                end
            end
        end
        total++;
        if (rdata_a !== 8'h3C) begin
            bad++; $display("FAIL rdata_hold_after_write got %h want 3c", rdata_a);
        end
    endtask

    task automatic test_refresh_preempt();
        sel = 1;
        do_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0102;
        // Backlog reaches 2 after the fourth grant, then refresh and DMA alternate.
        for (int c = 0; c < 8; c++) begin
            logic       isref;
            logic [7:0] ea;
            cycle();
            isref = (c == 4) || (c == 6);
            ea = isref ? ((c == 4) ? 8'h00 : 8'h01) : 8'h02;
            total++;
            if ({c_ras[2], c_cas[5], c_dack[9], c_a[1]} !== {1'b0, isref, !isref, ea}) begin
                bad++; $display("FAIL preempt_cycle%0d got %b_%b_%b_%h want %b_%b_%b_%h", c,
                    c_ras[2], c_cas[5], c_dack[9], c_a[1], 1'b0, isref, !isref, ea);
            end
        end
        dma_req = 1'b0;
        total++;
        if (miss_b !== 1'b0) begin
            bad++; $display("FAIL preempt_miss got %b want 0", miss_b);
        end
    endtask

    task automatic test_resync();
        int nack, nact;
        sel = 1;
        do_reset();
        cycle();
        total++;
        if (c_ras[2] !== 1'b1) begin
            bad++; $display("FAIL resync_first_idle got %b want 1", c_ras[2]);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3344;
        step(4'd10);
        for (int p = 1; p <= 4; p++) step(4'(p));
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            step(4'd5);
            if (cack_b !== 1'b0) nack++;
        end
        total++;
        if ({ras_b, cas_b, nack} !== {1'b0, 1'b0, 32'd0}) begin
            bad++; $display("FAIL stuck_phase got ras=%b cas=%b acks=%0d want 0 0 0", ras_b, cas_b, nack);
        end
        step(4'd0);
        step(4'd0);
        cpu_req = 1'b0;
        total++;
        if ({ras_b, cas_b, we_b, oe_b, cack_b} !== 5'b11100) begin
            bad++; $display("FAIL bad_tnum got %b want 11100", {ras_b, cas_b, we_b, oe_b, cack_b});
        end
        nact = 0;
        for (int p = 1; p <= 9; p++) begin
            step(4'(p));
            if ({ras_b, cas_b, we_b, cack_b} !== 4'b1110) nact++;
        end
        total++;
        if (nact != 0) begin
            bad++; $display("FAIL unsynced_active got %0d want 0", nact);
        end
        cycle();
        total++;
        if ({c_ras[2], c_cas[5], c_a[1]} !== {1'b0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL resync_refresh got %b_%b_%h want 0_1_00", c_ras[2], c_cas[5], c_a[1]);
        end
        cycle();
        total++;
        if (c_ras[2] !== 1'b1) begin
            bad++; $display("FAIL resync_no_extra_refresh got %b want 1", c_ras[2]);
        end
    endtask

    task automatic test_reset_mid();
        int nerr;
        sel = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5678; cpu_wdata = 8'hA1;
        step(4'd10);
        for (int p = 1; p <= 5; p++) step(4'(p));
        total++;
        if ({ras_a, cas_a, we_a, oe_a, dout_a} !== {4'b0001, 8'hA1}) begin
            bad++; $display("FAIL mid_write_ph6 got %b_%h want 0001_a1", {ras_a, cas_a, we_a, oe_a}, dout_a);
        end
        #2;
        init_n = 1'b0;
        #1;
        total++;
        if ({ras_a, cas_a, we_a, oe_a, cack_a} !== 5'b11100) begin
            bad++; $display("FAIL async_abort got %b want 11100", {ras_a, cas_a, we_a, oe_a, cack_a});
        end
        @(posedge clk);
        #1;
        init_n = 1'b1;
        nerr = 0;
        for (int p = 6; p <= 9; p++) begin
            step(4'(p));
            if ({ras_a, cack_a} !== 2'b10) nerr++;
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL post_reset_wait got %0d active phases want 0", nerr);
        end
        cycle();
        cpu_req = 1'b0;
        total++;
        if ({c_a[1], c_a[4], c_we[6], c_cack[9], c_dout[5]} !== {8'h78, 8'h56, 1'b0, 1'b1, 8'hA1}) begin
            bad++; $display("FAIL retry_write got %h_%h_%b_%b_%h want 78_56_0_1_a1",
                c_a[1], c_a[4], c_we[6], c_cack[9], c_dout[5]);
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_cpu_read();
        test_priority();
        test_refresh_preempt();
        test_resync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
